// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision adder issue/collect slice.
package fp_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned MAN_W       = 23;
    localparam int unsigned ADD_LATENCY = 5;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } op_pair_t;

    // Subnormals (exponent 0) become signed zero; everything else passes through.
    function automatic logic [FP_W-1:0] ftz(input logic [FP_W-1:0] x);
        if (x[FP_W-2 -: EXP_W] == '0) begin
            return {x[FP_W-1], {(FP_W-1){1'b0}}};
        end
        return x;
    endfunction

endpackage

// File: rtl/fp_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only alongside a pop.
module fp_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_add_issue.sv
// Credit-limited issue/collect wrapper around the 5-stage pipelined single-precision adder.
// Optional macro FP_ADD_ISSUE_FTZ_EN flushes subnormal operands to signed zero at issue.
module fp_add_issue
    import fp_pkg::*;
#(
    parameter int unsigned IN_DEPTH    = 4,
    parameter int unsigned RES_DEPTH   = 8,
    parameter int unsigned ADD_LATENCY = fp_pkg::ADD_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            add_start,
    output logic [FP_W-1:0] add_op_a,
    output logic [FP_W-1:0] add_op_b,
    input  logic            add_done,
    input  logic [FP_W-1:0] add_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic            busy,
    output logic            err
);

    localparam int unsigned IN_CW = $clog2(IN_DEPTH) + 1;
    localparam int unsigned IW    = $clog2(RES_DEPTH) + 1;

    if ((IN_DEPTH < 2) || ((IN_DEPTH & (IN_DEPTH - 1)) != 0) ||
        (RES_DEPTH < 2) || ((RES_DEPTH & (RES_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fp_add_issue: FIFO depths must be powers of 2 and at least 2");
    end
    if (RES_DEPTH < ADD_LATENCY + 1) begin : g_low_throughput
        $warning("fp_add_issue: RES_DEPTH below ADD_LATENCY+1 limits throughput");
    end

    op_pair_t          in_pair, in_head;
    logic              in_full, in_empty;
    logic [IN_CW-1:0]  in_count;
    logic              res_full, res_empty, res_pop;
    logic [IW-1:0]     res_count;
    logic              issue;
    logic [FP_W-1:0]   issue_a, issue_b;

    logic              add_start_q;
    logic [FP_W-1:0]   op_a_q, op_b_q;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              err_q, err_d;

    assign in_pair  = '{a: in_a, b: in_b};
    assign in_ready = !in_full;

    fp_fifo #(
        .DATA_W ($bits(op_pair_t)),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .wr_data (in_pair),
        .pop     (issue),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    // Credit check: every op in flight must already own a result slot.
    assign issue = !in_empty &&
                   (({1'b0, inflight_q} + {1'b0, res_count}) < (IW+1)'(RES_DEPTH));

`ifdef FP_ADD_ISSUE_FTZ_EN
    assign issue_a = ftz(in_head.a);
    assign issue_b = ftz(in_head.b);
`else
    assign issue_a = in_head.a;
    assign issue_b = in_head.b;
`endif

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !add_done) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && add_done && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (add_done && ((inflight_q == '0) || (res_full && !res_pop))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_start_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            add_start_q <= issue;
            if (issue) begin
                op_a_q <= issue_a;
                op_b_q <= issue_b;
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign res_pop = out_valid && out_ready;

    fp_fifo #(
        .DATA_W (FP_W),
        .DEPTH  (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (add_done),
        .wr_data (add_res),
        .pop     (res_pop),
        .rd_data (out_res),
        .full    (res_full),
        .empty   (res_empty),
        .count   (res_count)
    );

    assign out_valid = !res_empty;
    assign add_start = add_start_q;
    assign add_op_a  = op_a_q;
    assign add_op_b  = op_b_q;
    assign err       = err_q;
    assign busy      = (in_count != '0) || (inflight_q != '0) || (res_count != '0);

endmodule

// File: tb/tb_fp_add_issue.sv
// Directed bench for fp_add_issue with a 5-cycle behavioural adder; honours FP_ADD_ISSUE_FTZ_EN.
module tb_fp_add_issue;

    localparam logic [31:0] ONE = 32'h3F800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        add_start;
    logic [31:0] add_op_a, add_op_b;
    logic        add_done;
    logic [31:0] add_res;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic        busy, err;
    logic        inj_done;

    logic [4:0]  pv;
    logic [31:0] pr [5];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          nstart, first_start, last_start, sent;
    logic        acc;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    fp_add_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_start (add_start),
        .add_op_a  (add_op_a),
        .add_op_b  (add_op_b),
        .add_done  (add_done),
        .add_res   (add_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [63:0] sp2dp(input logic [31:0] s);
        int e;
        if (s[30:23] == 8'd0) return {s[31], 63'd0};
        e = int'(s[30:23]) + 896;
        return {s[31], e[10:0], s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        int e;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int2sp(input int i);
        return dp2sp($realtobits(real'(i)));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return dp2sp($realtobits($bitstoreal(sp2dp(a)) + $bitstoreal(sp2dp(b))));
    endfunction

    // Behavioural adder: fixed 5-cycle latency, in order, cleared by the shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[3:0], add_start};
            pr[0] <= fadd(add_op_a, add_op_b);
            for (int k = 1; k < 5; k++) pr[k] <= pr[k-1];
        end
    end

    assign add_done = pv[4] | inj_done;
    assign add_res  = inj_done ? 32'hDEADBEEF : pr[4];

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got_v, exp_v);
        end
    endtask

    // Record what the coming edge will do, then move to the next falling edge.
    task automatic tick();
        if (out_valid && out_ready) got.push_back(out_res);
        if (add_start) begin
            if (nstart == 0) first_start = cyc;
            nstart++;
            last_start = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic mon_clear();
        got.delete();
        nstart      = 0;
        first_start = 0;
        last_start  = 0;
        sent        = 0;
    endtask

    task automatic single_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        check("single_in_ready", in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        check("single_start_c0", add_start, 0);
        tick();
        check("single_start_c1", add_start, 1);
        check("single_op_a", add_op_a, a);
        check("single_op_b", add_op_b, b);
        tick();
        check("single_start_c2", add_start, 0);
        repeat (4) tick();
        check("single_outv_c6", out_valid, 0);
        tick();
        check("single_outv_c7", out_valid, 1);
        check("single_res", out_res, r);
        check("single_err", err, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_outv_pop", out_valid, 0);
        check("single_busy_pop", busy, 0);
    endtask

    task automatic drive_step(input int total);
        in_valid = (sent < total);
        in_a     = int2sp(sent);
        in_b     = ONE;
        acc      = in_valid && in_ready;
        tick();
        if (acc) sent++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; inj_done = 1'b0;
        mon_clear();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_add_start", add_start, 0);
        check("rst_op_a", add_op_a, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);

        // Single op, idle latency.
        single_op(32'h3F800000, 32'h40000000, 32'h40400000);

        // Streaming: back-to-back issue, results in order.
        mon_clear();
        out_ready = 1'b1;
        for (int c = 0; c < 200 && got.size() < 16; c++) drive_step(16);
        in_valid = 1'b0;
        check("stream_count", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("stream_res%0d", i), got[i], int2sp(i + 1));
        check("stream_starts", nstart, 16);
        check("stream_b2b", last_start - first_start, 15);
        check("stream_err", err, 0);

        // Backpressure: credits stop issue at 8, operand FIFO then fills.
        mon_clear();
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) drive_step(20);
        check("bp_starts", nstart, 8);
        check("bp_accepted", sent, 12);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_err", err, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got.size() < 20; c++) drive_step(20);
        in_valid = 1'b0;
        check("bp_count", got.size(), 20);
        for (int i = 0; i < got.size() && i < 20; i++)
            check($sformatf("bp_res%0d", i), got[i], int2sp(i + 1));
        check("bp_err_end", err, 0);
        check("bp_busy_end", busy, 0);
        out_ready = 1'b0;

        // Spurious add_done with nothing in flight.
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        check("spur_err", err, 1);
        repeat (3) tick();
        check("spur_err_sticky", err, 1);
        rst = 1'b1;
        #1;
        check("spur_err_rst", err, 0);
        check("spur_outv_rst", out_valid, 0);
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset between edges in the middle of a stream.
        mon_clear();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) drive_step(6);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_add_start", add_start, 0);
        check("arst_op_a", add_op_a, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_res", out_res, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        single_op(int2sp(5), ONE, int2sp(6));

        // Subnormal operands at issue.
        in_valid = 1'b1; in_a = 32'h00000001; in_b = 32'h80400000;
        tick();
        in_valid = 1'b0;
        tick();
        check("ftz_start", add_start, 1);
`ifdef FP_ADD_ISSUE_FTZ_EN
        check("ftz_op_a", add_op_a, 32'h00000000);
        check("ftz_op_b", add_op_b, 32'h80000000);
`else
        check("ftz_op_a", add_op_a, 32'h00000001);
        check("ftz_op_b", add_op_b, 32'h80400000);
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) tick();
        check("ftz_busy_end", busy, 0);
        check("ftz_err_end", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
